// File: rtl/vector_feeder.sv
// vector_feeder: FIFO-buffered operand feeder for the systolic skew delay lines.
// Each tile streams TILE_ROWS vectors, inserting zero bubbles when the FIFO
// is starved. It then drives FLUSH_CYCLES zero vectors and pulses tile_done.
// Optional bubble counter: define VECTOR_FEEDER_STALL_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for the first row of a tile
// STREAM | popping rows; a zero bubble is driven when the FIFO is empty
// FLUSH  | zero vectors that drain the skew chain, no pops
// DONE   | end of tile; tile_done shows on the following cycle
module vector_feeder #(
  parameter int DATA_SIZE    = 16,
  parameter int SIZE         = 4,
  parameter int DEPTH        = 4,
  parameter int TILE_ROWS    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_SIZE*SIZE-1:0] bus_in_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [DATA_SIZE*SIZE-1:0] bus_out_o,
  output logic                      out_valid_o,
  output logic                      tile_done_o,
  output logic                      busy_o,
  output logic [15:0]               stall_count_o
);
  localparam int W  = DATA_SIZE * SIZE;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS + 1) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [RW-1:0] LAST_ROW   = RW'(TILE_ROWS - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t         state_q;
  logic [RW-1:0]  row_cnt_q;
  logic [FW-1:0]  flush_cnt_q;
  logic [W-1:0]   bus_out_q;
  logic           out_valid_q;
  logic           tile_done_q;

  logic [W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop, fifo_empty;

  // ready only looks at the registered occupancy, never at a same-cycle pop
  assign in_ready_o = (count_q < DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = ((state_q == S_IDLE) || (state_q == S_STREAM)) && !fifo_empty;

  // occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // FIFO storage; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_in_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // tile sequencer with registered bus outputs; zero is the default drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
      bus_out_q   <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      bus_out_q   <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            bus_out_q   <= mem_q[rd_ptr_q];
            out_valid_q <= 1'b1;
            row_cnt_q   <= RW'(1);
            if (TILE_ROWS == 1) begin
              state_q     <= S_FLUSH;
              flush_cnt_q <= FLUSH_LOAD;
            end else begin
              state_q <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (!fifo_empty) begin
            bus_out_q   <= mem_q[rd_ptr_q];
            out_valid_q <= 1'b1;
            row_cnt_q   <= row_cnt_q + RW'(1);
            if (row_cnt_q == LAST_ROW) begin
              state_q     <= S_FLUSH;
              flush_cnt_q <= FLUSH_LOAD;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) state_q <= S_DONE;
          else                   flush_cnt_q <= flush_cnt_q - FW'(1);
        end
        S_DONE: begin
          tile_done_q <= 1'b1;
          row_cnt_q   <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_out_o   = bus_out_q;
  assign out_valid_o = out_valid_q;
  assign tile_done_o = tile_done_q;
  assign busy_o      = (state_q != S_IDLE);

`ifdef VECTOR_FEEDER_STALL_COUNT_EN
  logic [15:0] stall_q;

  // saturating count of STREAM cycles that had to drive a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == S_STREAM) && fifo_empty && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_vector_feeder.sv
// Bench for vector_feeder: scoreboard monitor on the default instance, a tile
// table, directed backpressure / async-reset sequences, and a second instance
// with one-row tiles checked against a per-cycle expectation table.
module tb_vector_feeder;
  localparam int DS = 16, SZ = 4, W = DS * SZ;
  localparam int DEPTH = 4, TR = 8, FC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [W-1:0] bus_in, bus_out;
  logic in_valid, in_ready, out_valid, tile_done, busy;
  logic [15:0] stall_count;

  logic [W-1:0] c_bus_in, c_bus_out;
  logic c_in_valid, c_in_ready, c_out_valid, c_tile_done, c_busy;
  logic [15:0] c_stall;

  vector_feeder #(.DATA_SIZE(DS), .SIZE(SZ), .DEPTH(DEPTH), .TILE_ROWS(TR), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in_i(bus_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .bus_out_o(bus_out), .out_valid_o(out_valid), .tile_done_o(tile_done), .busy_o(busy),
    .stall_count_o(stall_count));

  vector_feeder #(.DATA_SIZE(DS), .SIZE(SZ), .DEPTH(DEPTH), .TILE_ROWS(1), .FLUSH_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus_in_i(c_bus_in), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .bus_out_o(c_bus_out), .out_valid_o(c_out_valid), .tile_done_o(c_tile_done), .busy_o(c_busy),
    .stall_count_o(c_stall));

  int checks = 0;
  int errors = 0;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] vec(input int r);
    logic [15:0] b;
    b = 16'(r);
    return {b + 16'h3000, b + 16'h2000, b + 16'h1000, b};
  endfunction

  // scoreboard and observed tile structure
  logic [W-1:0] sbq[$];
  int sbt[$];
  int cyc = 0, done_cnt = 0, rows_in_tile = 0, zeros_since_row = 0;
  int bubbles = 0, last_bubbles = 0, since_done = 1000, first_gap = 0, first_lat = 0, lat = 0;
  int ready_low_seen = 0;
  int exp_stall = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      sbt.delete();
      rows_in_tile = 0;
      zeros_since_row = 0;
      bubbles = 0;
      since_done = 1000;
    end else begin
      since_done++;
      if (tile_done) begin
        check_i("done_rows", rows_in_tile, TR);
        check_i("done_flush_zeros", zeros_since_row, FC);
        check_i("done_out_valid", int'(out_valid), 0);
        check_i("done_busy", int'(busy), 0);
        done_cnt++;
        last_bubbles = bubbles;
        bubbles = 0;
        rows_in_tile = 0;
        since_done = 0;
      end
      if (out_valid) begin
        check_i("row_busy", int'(busy), 1);
        check_i("row_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          lat = cyc - sbt.pop_front();
          if (rows_in_tile == 0) begin
            first_gap = since_done;
            first_lat = lat;
          end
          check_v("row_data", bus_out, sbq.pop_front());
        end
        rows_in_tile++;
        zeros_since_row = 0;
      end else begin
        check_v("zero_bus", bus_out, '0);
        if (rows_in_tile > 0 && rows_in_tile < TR) bubbles++;
        zeros_since_row++;
      end
      if (!in_ready) begin
        ready_low_seen = 1;
        check_i("full_occupancy", sbq.size(), DEPTH);
      end
      if (in_valid && in_ready) begin
        sbq.push_back(bus_in);
        sbt.push_back(cyc);
      end
    end
  end

  function automatic int stall_model();
`ifdef VECTOR_FEEDER_STALL_COUNT_EN
    return (exp_stall > 65535) ? 65535 : exp_stall;
`else
    return 0;
`endif
  endfunction

  task automatic send(input int r);
    int g = 0;
    bus_in = vec(r);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_i("send_accepted", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_i("tile_done_in_time", int'(done_cnt >= target), 1);
  endtask

  task automatic run_tile(input int base, input int split, input int gap, input int exp_bub);
    int d0;
    d0 = done_cnt;
    for (int j = 0; j < TR; j++) begin
      if (j == split && gap > 0) idle(gap);
      send(base + j);
    end
    idle(1);
    wait_done(d0 + 1);
    idle(3);
    exp_stall += exp_bub;
    check_i("tile_done_once", done_cnt, d0 + 1);
    check_i("tile_bubbles", last_bubbles, exp_bub);
    check_i("first_latency", first_lat, 2);
    check_i("sb_drained", sbq.size(), 0);
    check_i("stall_count", int'(stall_count), stall_model());
  endtask

  typedef struct {
    int base;
    int split;
    int gap;
    int exp_bub;
  } tile_vec_t;

  typedef struct {
    logic v;
    logic d;
    logic b;
    int   row;
  } cexp_t;

  tile_vec_t ttab[4];
  cexp_t ctab[11];
  int d0;
  int seen;

  initial begin
    ttab = '{'{1, 8, 0, 0}, '{17, 3, 2, 2}, '{33, 5, 1, 1}, '{49, 1, 3, 3}};
    ctab = '{'{1'b1, 1'b0, 1'b1, 501}, '{1'b0, 1'b0, 1'b1, 0}, '{1'b0, 1'b1, 1'b0, 0},
             '{1'b1, 1'b0, 1'b1, 502}, '{1'b0, 1'b0, 1'b1, 0}, '{1'b0, 1'b1, 1'b0, 0},
             '{1'b1, 1'b0, 1'b1, 503}, '{1'b0, 1'b0, 1'b1, 0}, '{1'b0, 1'b1, 1'b0, 0},
             '{1'b0, 1'b0, 1'b0, 0},   '{1'b0, 1'b0, 1'b0, 0}};

    rst_n = 1'b0;
    bus_in = '0;
    in_valid = 1'b0;
    c_bus_in = '0;
    c_in_valid = 1'b0;

    // reset values before any clock edge
    #3;
    check_v("rst_bus_out", bus_out, '0);
    check_i("rst_out_valid", int'(out_valid), 0);
    check_i("rst_tile_done", int'(tile_done), 0);
    check_i("rst_in_ready", int'(in_ready), 1);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_stall", int'(stall_count), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // tile table: back-to-back and starved input patterns
    for (int t = 0; t < 4; t++)
      run_tile(ttab[t].base, ttab[t].split, ttab[t].gap, ttab[t].exp_bub);

    // backpressure: 16 vectors with in_valid held high
    ready_low_seen = 0;
    d0 = done_cnt;
    for (int v = 0; v < 16; v++) send(101 + v);
    idle(1);
    wait_done(d0 + 2);
    idle(3);
    check_i("bp_tiles", done_cnt, d0 + 2);
    check_i("bp_ready_dropped", ready_low_seen, 1);
    check_i("bp_tile2_gap", first_gap, 1);
    check_i("bp_bubbles", last_bubbles, 0);
    check_i("bp_drained", sbq.size(), 0);
    check_i("bp_stall", int'(stall_count), stall_model());

    // asynchronous reset while row 5 of 8 is on the bus
    seen = 0;
    for (int j = 0; j < TR && seen == 0; j++) begin
      bus_in = vec(201 + j);
      in_valid = 1'b1;
      @(negedge clk);
      if (out_valid && bus_out[15:0] == 16'd205) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_i("row5_reached", seen, 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_v("arst_bus_out", bus_out, '0);
    check_i("arst_out_valid", int'(out_valid), 0);
    check_i("arst_busy", int'(busy), 0);
    check_i("arst_in_ready", int'(in_ready), 1);
    check_i("arst_stall", int'(stall_count), 0);
    exp_stall = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_i("post_rst_out_valid", int'(out_valid), 0);
      check_i("post_rst_busy", int'(busy), 0);
      check_i("post_rst_in_ready", int'(in_ready), 1);
    end
    @(posedge clk);
    #1;
    run_tile(301, 8, 0, 0);

    // one-row tiles with a single flush cycle
    c_in_valid = 1'b1;
    c_bus_in = vec(501);
    @(posedge clk);
    #1;
    c_bus_in = vec(502);
    @(posedge clk);
    #1;
    c_bus_in = vec(503);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      check_i("c_out_valid", int'(c_out_valid), int'(ctab[i].v));
      check_i("c_tile_done", int'(c_tile_done), int'(ctab[i].d));
      check_i("c_busy", int'(c_busy), int'(ctab[i].b));
      check_v("c_bus_out", c_bus_out, ctab[i].v ? vec(ctab[i].row) : '0);
      if (i == 0) begin
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
      end
    end
    check_i("c_stall", int'(c_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_feeder.md
# vector_feeder

Upstream input stage for the skew delay lines in front of the systolic array. Accepts packed operand vectors over a valid/ready handshake and buffers them in a small FIFO. Drives one vector per clock onto a free-running bus that the delay lines shift every cycle, inserting zero bubbles when starved. After each tile of `tile_rows` vectors it emits `flush_cycles` zero vectors to drain the skew chain, then pulses `tile_done`.

## Interface
- `data_size`, 16, bits per lane
- `size`, 4, lanes per vector
- `depth`, 4, FIFO entries (power of two, ≥2)
- `tile_rows`, 8, vectors per tile (≥1)
- `flush_cycles`, 4, zero vectors after each tile (≥1); normally set to the downstream delay `cycle`

- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — asynchronous active-low reset
- `bus_in` input data_size*size — packed input vector, lane i at [data_size*(i+1)-1 : data_size*i]
- `in_valid` input 1 — `bus_in` valid
- `in_ready` output 1 — FIFO can accept
- `bus_out` output data_size*size — registered vector to the delay lines
- `out_valid` output 1 — `bus_out` carries a real row (0 for bubble, flush and done cycles)
- `tile_done` output 1 — one-cycle pulse after a tile's flush completes
- `busy` output 1 — state ≠ IDLE
- `stall_count` output 16 — bubble counter (see Configuration)

## Operation
- FIFO: `depth` entries, occupancy counter of width clog2(depth)+1.
- `in_ready` = (count < depth), combinational from registered count; it does not look ahead to a same-cycle pop.
- Push on `in_valid && in_ready`. There is no bypass: a pushed entry is poppable from the next cycle on.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - FIFO empty: outputs zero, stay in IDLE.
  - FIFO non-empty: pop, `bus_out`<=head, `out_valid`<=1, row_cnt<=1. If tile_rows==1 go to FLUSH, else go to STREAM.
- STREAM:
  - FIFO non-empty: pop, drive head with `out_valid`=1, row_cnt++. When row_cnt reaches tile_rows, go to FLUSH.
  - FIFO empty: `bus_out`<=0, `out_valid`<=0, a bubble that does not advance row_cnt.
- FLUSH: `bus_out`<=0, `out_valid`<=0 for exactly `flush_cycles` cycles, then go to DONE. No pops.
- DONE: one cycle, `tile_done`=1, outputs zero, row_cnt<=0, then go to IDLE.
- Pushes are accepted in every state. Simultaneous push and pop leaves count unchanged.
- Reset mid-tile discards FIFO contents, row_cnt and the flush counter.

## Timing
- Reset values: `bus_out`=0, `out_valid`=0, `tile_done`=0, `busy`=0, `stall_count`=0, `in_ready`=1, state IDLE.
- `bus_out`, `out_valid` and `tile_done` are registered. `busy` and `in_ready` are decoded from registers.
- Latency with an empty FIFO: a vector accepted at edge k appears on `bus_out` after edge k+1.
- Back-to-back input at one vector per clock sustains one row per clock on `bus_out`.
- Per-tile cycle count with no starvation: tile_rows + flush_cycles + 1.
- After DONE, IDLE lasts at least one cycle before the next tile's first row.

## Configuration
- `VECTOR_FEEDER_STALL_COUNT_EN` defined:
  - `stall_count` increments on each STREAM bubble cycle.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Macro undefined: `stall_count` is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then check outputs: hold `rst_n`=0 → `bus_out`=0, `out_valid`=0, `in_ready`=1, `busy`=0.
- Full tile, single-lane ramp: 8 vectors with lane0 = 1..8 pushed back-to-back (defaults) → `out_valid` high for 8 consecutive cycles with rows 1..8 in order, then 4 zero cycles, then a 1-cycle `tile_done`; first row one cycle after its acceptance.
- Starvation: push rows 1–3, wait 2 cycles, push rows 4–8 → `out_valid` pattern 1,1,1,0,0,…; row order preserved; `tile_done` exactly once; with the macro, `stall_count`=2 (plus 1 per extra idle STREAM cycle observed).
- Backpressure:
  - `in_valid` held high while the first tile streams and `depth`=4 → `in_ready` drops at count 4.
  - No vector lost or duplicated.
  - Vectors 9..16 form the second tile after DONE and one IDLE cycle.
- Async reset mid-tile:
  - Assert `rst_n` low during row 5 of 8 → all outputs zero immediately, without waiting for a clock.
  - After release, FIFO empty and `busy`=0.
  - Next 8 pushes form a complete new tile.
- Parameter corner: tile_rows=1, flush_cycles=1 → each row followed by 1 zero cycle, then `tile_done`, then IDLE; 3-cycle cadence plus IDLE.
